// File: rtl/classification_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module   : classification_sweep_controller
// Brief    : Runs the seizure detector over every test-vector ROM entry once
//            and scores each result against the ROM's expected label.
// Revision : 1.0 - initial release
// ============================================================================
module classification_sweep_controller #(
    parameter int NUM_VECTORS    = 10,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [3:0]       vector_idx,
    input  logic             expected_label,
    input  logic             det_ready,
    output logic             det_data_valid,
    input  logic             det_result_valid,
    input  logic             det_seizure,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] fp_cnt,
    output logic [CNT_W-1:0] fn_cnt
);

    localparam int               SW            = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]    c_settle_last = SW'(SETTLE_CYCLES - 1);
    localparam logic [15:0]      c_to_last     = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       c_idx_last    = 4'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] c_cnt_max     = '1;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SETUP       = 3'd1,
        S_WAIT_READY  = 3'd2,
        S_LAUNCH      = 3'd3,
        S_WAIT_RESULT = 3'd4,
        S_SCORE       = 3'd5,
        S_DONE        = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [SW-1:0] r_settle_cnt;
    logic [15:0]   r_to_cnt;
    logic          r_rv_prev;
    logic          w_begin;
    logic          w_score;
    logic          w_expire;
    logic          w_last;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_cnt_max) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        w_begin        = 1'b0;
        w_score        = 1'b0;
        w_expire       = 1'b0;
        w_last         = (vector_idx == c_idx_last);
        busy           = (r_state != S_IDLE) && (r_state != S_DONE);
        done           = (r_state == S_DONE);
        det_data_valid = (r_state == S_LAUNCH);
        case (r_state)
            S_IDLE, S_DONE: begin
                if (abort)      w_next = S_IDLE;
                else if (start) begin
                    w_next  = S_SETUP;
                    w_begin = 1'b1;
                end
            end
            S_SETUP:       if (r_settle_cnt == c_settle_last) w_next = S_WAIT_READY;
            S_WAIT_READY:  if (det_ready) w_next = S_LAUNCH;
                           else if (r_to_cnt == c_to_last) w_expire = 1'b1;
            S_LAUNCH:      w_next = S_WAIT_RESULT;
            // Only a fresh rising edge counts; a level left high by the previous vector does not.
            S_WAIT_RESULT: if (det_result_valid && !r_rv_prev) w_next = S_SCORE;
                           else if (r_to_cnt == c_to_last) w_expire = 1'b1;
            S_SCORE:       w_score = 1'b1;
            default:       w_next = S_IDLE;
        endcase
        if (w_score || w_expire) w_next = w_last ? S_DONE : S_SETUP;
        if (abort && busy) begin
            w_next   = S_IDLE;
            w_score  = 1'b0;
            w_expire = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
            r_to_cnt     <= '0;
            r_rv_prev    <= 1'b0;
            vector_idx   <= '0;
            timeout_err  <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            fp_cnt       <= '0;
            fn_cnt       <= '0;
        end else begin
            r_rv_prev    <= det_result_valid;
            r_settle_cnt <= (r_state == S_SETUP) ? r_settle_cnt + 1'b1 : '0;
            r_to_cnt     <= (r_state == S_WAIT_READY || r_state == S_WAIT_RESULT) ?
                            r_to_cnt + 16'd1 : 16'd0;
            if (w_begin) begin
                vector_idx  <= '0;
                timeout_err <= 1'b0;
                pass_cnt    <= '0;
                fail_cnt    <= '0;
                fp_cnt      <= '0;
                fn_cnt      <= '0;
            end else if (w_score || w_expire) begin
                if (w_expire) begin
                    timeout_err <= 1'b1;
                    fail_cnt    <= sat_inc(fail_cnt);
                end else if (det_seizure == expected_label) begin
                    pass_cnt <= sat_inc(pass_cnt);
                end else begin
                    fail_cnt <= sat_inc(fail_cnt);
                    if (det_seizure) fp_cnt <= sat_inc(fp_cnt);
                    else             fn_cnt <= sat_inc(fn_cnt);
                end
                if (!w_last) vector_idx <= vector_idx + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_classification_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_classification_sweep_controller
// Brief    : Self-checking bench for the classification sweep controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_classification_sweep_controller;

    localparam int NV = 10;
    localparam int L  = 5;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] vector_idx;
    logic       expected_label;
    logic       det_ready;
    logic       det_data_valid;
    logic       det_result_valid;
    logic       det_seizure;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic [7:0] pass_cnt, fail_cnt, fp_cnt, fn_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Per-entry ROM label and detector behaviour: 0 echo, 1 invert, 2 silent, 3 no fresh edge
    bit labels[16];
    int modes[16];
    bit held_mode  = 1'b0;
    bit rand_ready = 1'b0;
    int lq_idx[$];
    int lq_t[$];

    classification_sweep_controller #(
        .NUM_VECTORS(NV), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(TO), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .vector_idx(vector_idx), .expected_label(expected_label),
        .det_ready(det_ready), .det_data_valid(det_data_valid),
        .det_result_valid(det_result_valid), .det_seizure(det_seizure),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fp_cnt(fp_cnt), .fn_cnt(fn_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && det_data_valid) begin
            lq_idx.push_back(int'(vector_idx));
            lq_t.push_back(cyc);
        end
    end

    // Detector + ROM model: result appears L cycles after the launch cycle.
    initial begin
        int cd;
        int cur_mode;
        bit cur_label;
        cd = 0; cur_mode = 0; cur_label = 0;
        det_result_valid = 0; det_seizure = 0; det_ready = 0; expected_label = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                det_result_valid = 0; det_seizure = 0; det_ready = 0; cd = 0;
            end else begin
                if (!held_mode) det_result_valid = 0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 1 && held_mode && cur_mode != 3) det_result_valid = 0;
                    if (cd == 0 && cur_mode < 2) begin
                        det_result_valid = 1;
                        det_seizure      = (cur_mode == 1) ? ~cur_label : cur_label;
                    end
                end
                if (det_data_valid) begin
                    cd        = L;
                    cur_mode  = modes[vector_idx];
                    cur_label = labels[vector_idx];
                end
                det_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
            end
            expected_label = labels[vector_idx];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 0; start = 0; abort = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", done, 1);
    endtask

    task automatic randomize_labels();
        for (int i = 0; i < 16; i++) begin
            labels[i] = 1'($urandom_range(1));
            modes[i]  = 0;
        end
    endtask

    // Reference scoring from the per-entry detector behaviour
    task automatic model(output int p, output int f, output int fp, output int fn, output int to);
        p = 0; f = 0; fp = 0; fn = 0; to = 0;
        for (int i = 0; i < NV; i++) begin
            if (modes[i] >= 2) begin
                f++; to = 1;
            end else if (modes[i] == 1) begin
                f++;
                if (labels[i]) fn++; else fp++;
            end else begin
                p++;
            end
        end
    endtask

    task automatic run_sweep(input string name, input bit held, input bit rready);
        int ep, ef, efp, efn, eto, ok;
        held_mode = held; rand_ready = rready;
        apply_reset();
        model(ep, ef, efp, efn, eto);
        lq_idx.delete(); lq_t.delete();
        pulse_start();
        wait_done(3000);
        check({name, "_pass"}, pass_cnt, ep);
        check({name, "_fail"}, fail_cnt, ef);
        check({name, "_fp"}, fp_cnt, efp);
        check({name, "_fn"}, fn_cnt, efn);
        check({name, "_timeout"}, timeout_err, eto);
        check({name, "_busy"}, busy, 0);
        check({name, "_launches"}, lq_idx.size(), NV);
        ok = 1;
        foreach (lq_idx[i]) if (lq_idx[i] != i) ok = 0;
        check({name, "_order"}, ok, 1);
    endtask

    initial begin
        int snap_pass;
        // Reset state
        randomize_labels();
        apply_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", vector_idx, 0);
        check("rst_ddv", det_data_valid, 0);
        check("rst_cnts", {pass_cnt, fail_cnt, fp_cnt, fn_cnt}, 0);
        check("rst_to", timeout_err, 0);

        // Echo detector
        randomize_labels();
        run_sweep("echo", 0, 0);
        check("echo_period", lq_t[1] - lq_t[0], 2 + 1 + 1 + L + 1);

        // Inverted result on idx 3 (label 0) and idx 7 (label 1)
        randomize_labels();
        labels[3] = 0; modes[3] = 1;
        labels[7] = 1; modes[7] = 1;
        run_sweep("invert", 0, 0);

        // Silent detector on idx 4
        randomize_labels();
        modes[4] = 2;
        run_sweep("silent", 0, 0);
        check("silent_gap", lq_t[5] - lq_t[4], 1 + TO + 2 + 1);

        // result_valid held high; idx 2 never gets a fresh edge
        randomize_labels();
        modes[2] = 3;
        run_sweep("held", 1, 0);
        check("held_total", pass_cnt + fail_cnt, NV);

        // Randomised sweeps with a sluggish ready line
        for (int r = 0; r < 3; r++) begin
            randomize_labels();
            for (int i = 0; i < NV; i++) begin
                int k = $urandom_range(9);
                modes[i] = (k < 7) ? 0 : (k < 9) ? 1 : 2;
            end
            run_sweep("rand", 0, 1);
        end

        // Abort during WAIT_RESULT of idx 6, then restart
        randomize_labels();
        held_mode = 0; rand_ready = 0;
        apply_reset();
        pulse_start();
        for (int n = 0; n < 500 && !(det_data_valid && vector_idx == 6); n++) @(negedge clk);
        repeat (2) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_idx", vector_idx, 6);
        check("abort_pass", pass_cnt, 6);
        check("abort_ddv", det_data_valid, 0);
        pulse_start();
        check("restart_idx", vector_idx, 0);
        check("restart_pass", pass_cnt, 0);
        check("restart_busy", busy, 1);
        wait_done(3000);
        check("restart_final", pass_cnt, NV);

        // start while busy, start+abort together, reset during LAUNCH
        randomize_labels();
        apply_reset();
        pulse_start();
        for (int n = 0; n < 500 && !(det_data_valid && vector_idx == 2); n++) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        check("midstart_idx", vector_idx, 2);
        check("midstart_pass", pass_cnt, 2);
        check("midstart_busy", busy, 1);
        snap_pass = int'(pass_cnt);
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        check("both_busy", busy, 0);
        check("both_pass", pass_cnt, snap_pass);
        pulse_start();
        for (int n = 0; n < 500 && !(det_data_valid && vector_idx == 3); n++) @(negedge clk);
        check("launch3_seen", det_data_valid, 1);
        rst_n = 0;
        #1;
        check("arst_ddv", det_data_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_idx", vector_idx, 0);
        check("arst_pass", pass_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
